// File: rtl/adc_uart_poller_pkg.sv
// Shared types and helpers for the ADC UART poller: FSM state encodings,
// baud divisor computation and the default command byte.
package adc_uart_poller_pkg;

  typedef enum logic [2:0] {StIdle, StSend, StRxHi, StRxLo, StStore, StGap} state_e;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  localparam logic [7:0] DefaultCmdBase = 8'hA1;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/adc_uart_poller_if.sv
// Board-side bundle of the ADC poller: UART pins, enable and per-channel results.
// The poller drives through master; user logic / the board observe through slave.
interface adc_uart_poller_if #(
    parameter int unsigned NUM_CH = 4
);
    logic                   enable;
    logic                   rx;
    logic                   tx;
    logic [16*NUM_CH-1:0]   ch_data;
    logic [NUM_CH-1:0]      ch_valid;
    logic                   ch_update;
    logic [2:0]             ch_index;
    logic                   busy;
    logic [7:0]             err_count;

    modport master (
        input  enable, rx,
        output tx, ch_data, ch_valid, ch_update, ch_index, busy, err_count
    );

    modport slave (
        output enable, rx,
        input  tx, ch_data, ch_valid, ch_update, ch_index, busy, err_count
    );
endinterface

// File: rtl/adc_uart_poller_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, start-bit revalidation at half a bit,
// mid-bit data sampling; one-cycle done / frame_err pulses.
module adc_uart_poller_rx_byte
    import adc_uart_poller_pkg::*;
#(
    parameter int unsigned DIV = 48
) (
    input  logic       clk12MHz,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       done,
    output logic       frame_err
);
    localparam logic [15:0] HalfM1 = 16'(DIV / 2 - 1);
    localparam logic [15:0] DivM1  = 16'(DIV - 1);

    logic      rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        done_q, done_d, ferr_q, ferr_d;

    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RxIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RxStart;
                    cnt_d   = HalfM1;
                end
            end
            RxStart: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rx_sync_q) begin
                    state_d = RxIdle;  // start too short: glitch
                end else begin
                    state_d = RxData;
                    cnt_d   = DivM1;
                    bit_d   = '0;
                end
            end
            RxData: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shreg_d = {rx_sync_q, shreg_q[7:1]};
                    cnt_d   = DivM1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RxStop;
                end
            end
            RxStop: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d = RxIdle;
                    done_d  = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    assign data      = shreg_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
endmodule

// File: rtl/adc_uart_poller.sv
// Round-robin ADC poller: sends CMD_BASE+k over UART, collects a two-byte result
// per channel, keeps per-channel data/valid and a saturating error count.
module adc_uart_poller
    import adc_uart_poller_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 12_000_000,
    parameter int unsigned BAUD        = 250_000,
    parameter int unsigned NUM_CH      = 4,
    parameter logic [7:0]  CMD_BASE    = DefaultCmdBase,
    parameter int unsigned TIMEOUT_CYC = 24_000,
    parameter int unsigned GAP_CYC     = 1_200
) (
    input logic               clk12MHz,
    input logic               rst,
    adc_uart_poller_if.master bus
);
    localparam int unsigned     DIV    = calc_div(CLK_HZ, BAUD);
    localparam int unsigned     ToW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [15:0]     DivM1  = 16'(DIV - 1);
    localparam logic [15:0]     GapM1  = 16'(GAP_CYC - 1);
    localparam logic [ToW-1:0]  ToLast = ToW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]      LastCh = 3'(NUM_CH - 1);

    state_e               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [8:0]           frame_q, frame_d;
    logic [3:0]           bits_q, bits_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [ToW-1:0]       to_q, to_d;
    logic [7:0]           hi_q, hi_d;
    logic [16*NUM_CH-1:0] data_q, data_d;
    logic [NUM_CH-1:0]    valid_q, valid_d;
    logic [2:0]           idx_q, idx_d, next_idx, send_idx;
    logic [7:0]           err_q, err_d;
    logic                 err_evt, start_send, timed_out;
    logic [7:0]           rx_data;
    logic                 rx_done, rx_ferr;

    adc_uart_poller_rx_byte #(.DIV(DIV)) u_rx (
        .clk12MHz  (clk12MHz),
        .rst       (rst),
        .rx        (bus.rx),
        .data      (rx_data),
        .done      (rx_done),
        .frame_err (rx_ferr)
    );

    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            frame_q <= '1;
            bits_q  <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            valid_q <= '0;
            idx_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            frame_q <= frame_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        frame_d    = frame_q;
        bits_d     = bits_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        hi_d       = hi_q;
        data_d     = data_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        err_d      = err_q;
        err_evt    = 1'b0;
        start_send = 1'b0;
        send_idx   = idx_q;
        next_idx   = (idx_q == LastCh) ? 3'd0 : idx_q + 3'd1;
        timed_out  = (to_q == ToLast);
        unique case (state_q)
            StIdle: start_send = bus.enable;
            StSend: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d = DivM1;
                    if (bits_q == '0) begin
                        state_d = StRxHi;
                        to_d    = '0;
                    end else begin
                        tx_d    = frame_q[0];
                        frame_d = {1'b1, frame_q[8:1]};
                        bits_d  = bits_q - 4'd1;
                    end
                end
            end
            StRxHi, StRxLo: begin
                to_d = to_q + 1'b1;
                if (rx_done) begin
                    if (state_q == StRxHi) begin
                        hi_d    = rx_data;
                        state_d = StRxLo;
                    end else begin
                        for (int k = 0; k < int'(NUM_CH); k++) begin
                            if (idx_q == 3'(k)) begin
                                data_d[16*k +: 16] = {hi_q, rx_data};
                                valid_d[k]         = 1'b1;
                            end
                        end
                        state_d = StStore;
                    end
                end else if (rx_ferr || timed_out) begin
                    err_evt = 1'b1;
                    state_d = StGap;
                    cnt_d   = GapM1;
                end
            end
            StStore: begin
                state_d = StGap;
                cnt_d   = GapM1;
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    idx_d      = next_idx;
                    send_idx   = next_idx;
                    start_send = bus.enable;
                    if (!bus.enable) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_send) begin
            state_d = StSend;
            tx_d    = 1'b0;
            frame_d = {1'b1, CMD_BASE + {5'd0, send_idx}};
            bits_d  = 4'd9;
            cnt_d   = DivM1;
        end
        if (err_evt && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    assign bus.tx        = tx_q;
    assign bus.ch_data   = data_q;
    assign bus.ch_valid  = valid_q;
    assign bus.ch_update = (state_q == StStore);
    assign bus.ch_index  = idx_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_adc_uart_poller.sv
// Directed bench for adc_uart_poller with a behavioural UART ADC model on the line.
module tb_adc_uart_poller;
    localparam int CLK_HZ      = 2_400_000;
    localparam int BAUD        = 100_000;
    localparam int DIV         = 24;
    localparam int NUM_CH      = 4;
    localparam int TIMEOUT_CYC = 1500;
    localparam int GAP_CYC     = 100;
    localparam logic [7:0] CMD_BASE = 8'hA1;

    logic clk12MHz = 1'b0;
    logic rst = 1'b0;
    always #5 clk12MHz = ~clk12MHz;

    adc_uart_poller_if #(.NUM_CH(NUM_CH)) bus ();

    adc_uart_poller #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .NUM_CH      (NUM_CH),
        .CMD_BASE    (CMD_BASE),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] tx_log[$];
    int cmd_seen = 0;
    logic [7:0] last_cmd = 8'h00;
    int upd_cnt = 0;

    logic [7:0] resp_hi = 8'h12;
    logic [7:0] resp_lo = 8'h34;
    int silent_ch = -1;
    int badstop_ch = -1;
    bit glitch_en = 1'b0;
    bit resp_busy = 1'b0;
    int resp_phase = 0;

    logic [7:0] exp_cmd [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA1};
    logic [3:0] exp_vld [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

    // Decodes bytes on tx, sampled mid-bit; aborted by rst like the DUT.
    initial begin : tx_monitor
        int cnt;
        int nb;
        bit act;
        bit prev;
        logic [7:0] sh;
        cnt = 0; nb = 0; act = 1'b0; prev = 1'b1; sh = '0;
        forever begin
            @(posedge clk12MHz);
            if (rst) begin
                act = 1'b0;
            end else if (!act) begin
                if (prev && !bus.tx) begin
                    act = 1'b1;
                    cnt = DIV + DIV / 2 - 2;
                    nb  = 0;
                end
            end else if (cnt != 0) begin
                cnt--;
            end else if (nb < 8) begin
                sh[nb] = bus.tx;
                nb++;
                cnt = DIV - 1;
            end else begin
                tx_log.push_back(sh);
                last_cmd = sh;
                cmd_seen++;
                act = 1'b0;
            end
            prev = bus.tx;
        end
    end

    initial begin : update_counter
        forever begin
            @(negedge clk12MHz);
            if (bus.ch_update === 1'b1) upd_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx = 1'b0;
        repeat (DIV) @(negedge clk12MHz);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (DIV) @(negedge clk12MHz);
        end
        bus.rx = stop;
        repeat (DIV) @(negedge clk12MHz);
        bus.rx = 1'b1;
    endtask

    task automatic do_response(input int ch);
        int wait_cyc;
        wait_cyc = 20 * DIV;
        if (glitch_en) begin
            repeat (5 * DIV) @(negedge clk12MHz);
            bus.rx = 1'b0;
            repeat (10) @(negedge clk12MHz);
            bus.rx = 1'b1;
            wait_cyc = 15 * DIV - 10;
        end
        repeat (wait_cyc) @(negedge clk12MHz);
        if (ch == silent_ch) return;
        resp_phase = 1;
        send_byte(resp_hi, 1'b1);
        resp_phase = 2;
        send_byte(resp_lo, (ch == badstop_ch) ? 1'b0 : 1'b1);
        resp_phase = 0;
    endtask

    initial begin : adc_model
        int handled;
        handled = 0;
        bus.rx = 1'b1;
        forever begin
            @(negedge clk12MHz);
            if (handled != cmd_seen) begin
                handled   = cmd_seen;
                resp_busy = 1'b1;
                do_response(int'(last_cmd) - int'(CMD_BASE));
                resp_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clk12MHz);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    task automatic wait_log(input int n, input int max_cyc, output bit ok);
        int i;
        i = 0;
        while (tx_log.size() < n && i < max_cyc) begin
            @(negedge clk12MHz);
            i++;
        end
        ok = (tx_log.size() >= n);
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        int i;
        i = 0;
        while ((bus.busy !== 1'b0 || resp_busy) && i < max_cyc) begin
            @(negedge clk12MHz);
            i++;
        end
        ok = (bus.busy === 1'b0 && !resp_busy);
    endtask

    task automatic apply_reset();
        @(negedge clk12MHz);
        bus.enable = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk12MHz);
        rst = 1'b0;
        tx_log.delete();
        silent_ch  = -1;
        badstop_ch = -1;
        glitch_en  = 1'b0;
        resp_hi    = 8'h12;
        resp_lo    = 8'h34;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        total++; if (bus.ch_data !== 64'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.ch_data); end
        total++; if (bus.ch_valid !== 4'b0) begin bad++; $display("FAIL reset_valid: got %b want 0000", bus.ch_valid); end
        total++; if (bus.ch_update !== 1'b0) begin bad++; $display("FAIL reset_update: got %b want 0", bus.ch_update); end
        total++; if (bus.ch_index !== 3'd0) begin bad++; $display("FAIL reset_index: got %0d want 0", bus.ch_index); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", bus.err_count); end
        repeat (50) @(negedge clk12MHz);
        total++; if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin bad++; $display("FAIL idle_hold: busy=%b tx=%b want 0/1", bus.busy, bus.tx); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int u0;
        apply_reset();
        u0 = upd_cnt;
        bus.enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_log(k, 4000, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL rr_cmd%0d: no byte seen, want %h", k, exp_cmd[k-1]);
            end else if (tx_log[k-1] !== exp_cmd[k-1]) begin
                bad++; $display("FAIL rr_cmd%0d: got %h want %h", k, tx_log[k-1], exp_cmd[k-1]);
            end
            total++;
            if (bus.ch_valid !== exp_vld[k-1]) begin
                bad++; $display("FAIL rr_valid%0d: got %b want %b", k, bus.ch_valid, exp_vld[k-1]);
            end
        end
        total++; if (bus.ch_data !== 64'h1234_1234_1234_1234) begin bad++; $display("FAIL rr_data: got %h want 1234123412341234", bus.ch_data); end
        total++; if (upd_cnt - u0 != 4) begin bad++; $display("FAIL rr_updates: got %0d want 4", upd_cnt - u0); end
        total++; if (bus.ch_index !== 3'd0) begin bad++; $display("FAIL rr_index: got %0d want 0", bus.ch_index); end
        bus.enable = 1'b0;
        wait_idle(4000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_idle: busy=%b want 0", bus.busy); end
        total++; if (upd_cnt - u0 != 5) begin bad++; $display("FAIL rr_updates_end: got %0d want 5", upd_cnt - u0); end
    endtask

    task automatic test_timeout();
        bit ok;
        apply_reset();
        silent_ch = 2;
        bus.enable = 1'b1;
        wait_log(3, 8000, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_cmd3: no third command"); end
        repeat (TIMEOUT_CYC - 50) @(negedge clk12MHz);
        total++; if (bus.err_count !== 8'd0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL to_early: err=%0d busy=%b want 0/1", bus.err_count, bus.busy);
        end
        repeat (100) @(negedge clk12MHz);
        total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL to_err: got %0d want 1", bus.err_count); end
        wait_log(4, 4000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL to_next: no fourth command, want a4"); end
        else if (tx_log[3] !== 8'hA4) begin bad++; $display("FAIL to_next: got %h want a4", tx_log[3]); end
        total++; if (bus.ch_valid !== 4'b0011) begin bad++; $display("FAIL to_valid: got %b want 0011", bus.ch_valid); end
        bus.enable = 1'b0;
        wait_idle(4000, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_idle: busy=%b want 0", bus.busy); end
        total++; if (bus.ch_valid !== 4'b1011) begin bad++; $display("FAIL to_valid_end: got %b want 1011", bus.ch_valid); end
        total++; if (bus.ch_data[47:32] !== 16'h0) begin bad++; $display("FAIL to_data2: got %h want 0000", bus.ch_data[47:32]); end
    endtask

    task automatic test_frame_err();
        bit ok;
        apply_reset();
        badstop_ch = 1;
        bus.enable = 1'b1;
        wait_log(3, 8000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fe_cmd3: no third command, want a3"); end
        else if (tx_log[2] !== 8'hA3) begin bad++; $display("FAIL fe_cmd3: got %h want a3", tx_log[2]); end
        total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL fe_err: got %0d want 1", bus.err_count); end
        total++; if (bus.ch_valid !== 4'b0001) begin bad++; $display("FAIL fe_valid: got %b want 0001", bus.ch_valid); end
        total++; if (bus.ch_data[31:16] !== 16'h0) begin bad++; $display("FAIL fe_data1: got %h want 0000", bus.ch_data[31:16]); end
        bus.enable = 1'b0;
        wait_idle(4000, ok);
        total++; if (!ok) begin bad++; $display("FAIL fe_idle: busy=%b want 0", bus.busy); end
        total++; if (bus.ch_valid !== 4'b0101 || bus.err_count !== 8'd1) begin
            bad++; $display("FAIL fe_end: valid=%b err=%0d want 0101/1", bus.ch_valid, bus.err_count);
        end
    endtask

    task automatic test_glitch();
        bit ok;
        apply_reset();
        glitch_en = 1'b1;
        resp_hi = 8'hBE;
        resp_lo = 8'hEF;
        bus.enable = 1'b1;
        wait_log(2, 4000, ok);
        total++; if (!ok) begin bad++; $display("FAIL gl_cmd2: no second command"); end
        total++; if (bus.ch_data[15:0] !== 16'hBEEF) begin bad++; $display("FAIL gl_data0: got %h want beef", bus.ch_data[15:0]); end
        total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL gl_err: got %0d want 0", bus.err_count); end
        bus.enable = 1'b0;
        wait_idle(4000, ok);
        total++; if (!ok) begin bad++; $display("FAIL gl_idle: busy=%b want 0", bus.busy); end
        total++; if (bus.ch_data[31:0] !== 32'hBEEF_BEEF || bus.ch_valid !== 4'b0011) begin
            bad++; $display("FAIL gl_end: data=%h valid=%b want beefbeef/0011", bus.ch_data[31:0], bus.ch_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int i;
        apply_reset();
        bus.enable = 1'b1;
        i = 0;
        while (bus.tx !== 1'b0 && i < 100) begin @(negedge clk12MHz); i++; end
        total++; if (bus.tx !== 1'b0) begin bad++; $display("FAIL rm_start: tx=%b want 0", bus.tx); end
        repeat (4 * DIV + DIV / 2) @(negedge clk12MHz);
        rst = 1'b1;
        @(negedge clk12MHz);
        rst = 1'b0;
        tx_log.delete();
        total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL rm_tx: got %b want 1", bus.tx); end
        total++; if (bus.busy !== 1'b0 || bus.ch_index !== 3'd0 || bus.err_count !== 8'd0) begin
            bad++; $display("FAIL rm_state: busy=%b idx=%0d err=%0d want 0/0/0", bus.busy, bus.ch_index, bus.err_count);
        end
        wait_log(1, 1000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rm_cmd: no command, want a1"); end
        else if (tx_log[0] !== 8'hA1) begin bad++; $display("FAIL rm_cmd: got %h want a1", tx_log[0]); end
        bus.enable = 1'b0;
        wait_idle(4000, ok);
        total++; if (!ok || bus.ch_valid !== 4'b0001) begin
            bad++; $display("FAIL rm_store: idle=%b valid=%b want 1/0001", ok, bus.ch_valid);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int i;
        apply_reset();
        bus.enable = 1'b1;
        i = 0;
        while (resp_phase != 2 && i < 4000) begin @(negedge clk12MHz); i++; end
        total++; if (resp_phase != 2) begin bad++; $display("FAIL ed_phase: got %0d want 2", resp_phase); end
        bus.enable = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ed_busy: got %b want 1", bus.busy); end
        wait_idle(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL ed_idle: busy=%b want 0", bus.busy); end
        total++; if (bus.ch_valid !== 4'b0001 || bus.ch_data[15:0] !== 16'h1234) begin
            bad++; $display("FAIL ed_store: valid=%b data=%h want 0001/1234", bus.ch_valid, bus.ch_data[15:0]);
        end
        total++; if (bus.tx !== 1'b1 || bus.ch_index !== 3'd1) begin
            bad++; $display("FAIL ed_state: tx=%b idx=%0d want 1/1", bus.tx, bus.ch_index);
        end
        repeat (200) @(negedge clk12MHz);
        total++; if (bus.busy !== 1'b0 || tx_log.size() != 1) begin
            bad++; $display("FAIL ed_stay: busy=%b cmds=%0d want 0/1", bus.busy, tx_log.size());
        end
        bus.enable = 1'b1;
        wait_log(2, 1000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ed_resume: no command, want a2"); end
        else if (tx_log[1] !== 8'hA2) begin bad++; $display("FAIL ed_resume: got %h want a2", tx_log[1]); end
        bus.enable = 1'b0;
        wait_idle(4000, ok);
    endtask

    initial begin
        bus.enable = 1'b0;
        test_reset();
        test_round_robin();
        test_timeout();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
